// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq
// Register-initialisation sequencer for the audio codec control port.
// Walks a table of register writes, issues each one to the SPI master,
// optionally reads it back and compares, retries failed attempts, and
// reports completion or the index of the entry that could not be written.
//
// Ports:
//   clk          system clock (shared with the SPI master)
//   rst          asynchronous active-low reset
//   start        one-cycle pulse, begins a pass (ignored while busy)
//   tbl_addr     table index; table answers combinationally on tbl_data
//   tbl_data     [6:0] register address, [7] ignored, [15:8] write data
//   spi_req      one-cycle transaction request to the SPI master
//   spi_wr_en    1 = write, 0 = read
//   spi_data_tx  transaction word, same layout as tbl_data
//   spi_data_rx  read data returned by the SPI master
//   spi_done     transaction-complete pulse from the SPI master
//   busy         pass in progress
//   cfg_done     last pass completed cleanly (level)
//   cfg_err      last pass aborted (level)
//   err_index    failing entry, meaningful while cfg_err is high
//
// Timing notes: the timeout window counts the request cycle itself, so an
// attempt is abandoned in the TIMEOUT-th cycle after spi_req unless
// spi_done arrives in that same cycle. GAP_WAIT lasts exactly GAP cycles
// (GAP must be at least 1).

module codec_cfg_seq #(
    parameter int NUM_REGS  = 8,
    parameter int VERIFY    = 1,
    parameter int TIMEOUT   = 255,
    parameter int RETRY_MAX = 3,
    parameter int GAP       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic        spi_req,
    output logic        spi_wr_en,
    output logic [15:0] spi_data_tx,
    input  logic [7:0]  spi_data_rx,
    input  logic        spi_done,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [3:0]  err_index
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_WR_REQ, ST_WR_WAIT, ST_RD_REQ, ST_RD_WAIT,
        ST_CHECK, ST_GAP_WAIT, ST_NEXT, ST_FIN, ST_FAIL
    } state_t;

    localparam logic [3:0] LAST_IDX  = 4'(NUM_REGS - 1);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);
    localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);

    state_t      state_r, state_s;
    state_t      after_gap_r, after_gap_s;
    logic [3:0]  idx_r, idx_s;
    logic [7:0]  retry_r, retry_s;
    logic [7:0]  tmo_r, tmo_s;
    logic [7:0]  gap_r, gap_s;
    logic [7:0]  rd_data_r, rd_data_s;
    logic [15:0] tx_r, tx_s;
    logic        wr_en_r, wr_en_s;
    logic        req_r, req_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic [3:0]  eidx_r, eidx_s;
    logic        attempt_fail_s;

    // Next-state and next-register computation for the whole sequencer.
    always_comb begin
        state_s        = state_r;
        after_gap_s    = after_gap_r;
        idx_s          = idx_r;
        retry_s        = retry_r;
        tmo_s          = (tmo_r == 8'hFF) ? tmo_r : tmo_r + 8'd1;
        gap_s          = gap_r;
        rd_data_s      = rd_data_r;
        tx_s           = tx_r;
        wr_en_s        = wr_en_r;
        done_s         = done_r;
        err_s          = err_r;
        eidx_s         = eidx_r;
        attempt_fail_s = 1'b0;

        case (state_r)
            ST_IDLE, ST_FIN, ST_FAIL: begin
                if (start) begin
                    done_s  = 1'b0;
                    err_s   = 1'b0;
                    idx_s   = 4'd0;
                    retry_s = 8'd0;
                    state_s = ST_FETCH;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH:   state_s = ST_WR_REQ;
            ST_WR_REQ:  state_s = ST_WR_WAIT;
            ST_WR_WAIT: begin
                // spi_done takes priority over an expiring timeout.
                if (spi_done) begin
                    gap_s       = 8'd0;
                    after_gap_s = (VERIFY != 0) ? ST_RD_REQ : ST_NEXT;
                    state_s     = ST_GAP_WAIT;
                end else if (tmo_r >= TMO_LAST) begin
                    attempt_fail_s = 1'b1;
                end else begin
                    state_s = ST_WR_WAIT;
                end
            end
            ST_RD_REQ:  state_s = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (spi_done) begin
                    rd_data_s = spi_data_rx;
                    state_s   = ST_CHECK;
                end else if (tmo_r >= TMO_LAST) begin
                    attempt_fail_s = 1'b1;
                end else begin
                    state_s = ST_RD_WAIT;
                end
            end
            ST_CHECK: begin
                if (rd_data_r == tx_r[15:8]) begin
                    gap_s       = 8'd0;
                    after_gap_s = ST_NEXT;
                    state_s     = ST_GAP_WAIT;
                end else begin
                    attempt_fail_s = 1'b1;
                end
            end
            ST_GAP_WAIT: begin
                if (gap_r >= GAP_LAST) begin
                    state_s = after_gap_r;
                end else begin
                    gap_s = gap_r + 8'd1;
                end
            end
            ST_NEXT: begin
                retry_s = 8'd0;
                if (idx_r == LAST_IDX) begin
                    done_s  = 1'b1;
                    state_s = ST_FIN;
                end else begin
                    idx_s   = idx_r + 4'd1;
                    state_s = ST_FETCH;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        // A failed attempt either retries the same entry after a gap or aborts.
        if (attempt_fail_s) begin
            if (retry_r < RETRY_LIM) begin
                retry_s     = retry_r + 8'd1;
                gap_s       = 8'd0;
                after_gap_s = ST_WR_REQ;
                state_s     = ST_GAP_WAIT;
            end else begin
                eidx_s  = idx_r;
                err_s   = 1'b1;
                state_s = ST_FAIL;
            end
        end else begin
            attempt_fail_s = 1'b0;
        end

        // The transaction word is loaded on entry to WR_REQ so it is already
        // valid alongside spi_req; tbl_addr has equalled idx since FETCH.
        if (state_s == ST_WR_REQ) begin
            tx_s    = tbl_data;
            wr_en_s = 1'b1;
            tmo_s   = 8'd0;
        end else if (state_s == ST_RD_REQ) begin
            wr_en_s = 1'b0;
            tmo_s   = 8'd0;
        end else begin
            tx_s = tx_s;
        end

        req_s  = (state_s == ST_WR_REQ) || (state_s == ST_RD_REQ);
        busy_s = !((state_s == ST_IDLE) || (state_s == ST_FIN) || (state_s == ST_FAIL));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            after_gap_r <= ST_IDLE;
            idx_r       <= 4'd0;
            retry_r     <= 8'd0;
            tmo_r       <= 8'd0;
            gap_r       <= 8'd0;
            rd_data_r   <= 8'd0;
            tx_r        <= 16'd0;
            wr_en_r     <= 1'b1;
            req_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            eidx_r      <= 4'd0;
        end else begin
            after_gap_r <= after_gap_s;
            idx_r       <= idx_s;
            retry_r     <= retry_s;
            tmo_r       <= tmo_s;
            gap_r       <= gap_s;
            rd_data_r   <= rd_data_s;
            tx_r        <= tx_s;
            wr_en_r     <= wr_en_s;
            req_r       <= req_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            eidx_r      <= eidx_s;
        end
    end

    assign tbl_addr    = idx_r;
    assign spi_req     = req_r;
    assign spi_wr_en   = wr_en_r;
    assign spi_data_tx = tx_r;
    assign busy        = busy_r;
    assign cfg_done    = done_r;
    assign cfg_err     = err_r;
    assign err_index   = eidx_r;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Self-checking bench for codec_cfg_seq. DUT a: NUM_REGS=3, VERIFY=1,
// TIMEOUT=20, RETRY_MAX=3, GAP=4. DUT b: same but VERIFY=0.
// Each DUT has a behavioural SPI master answering LAT cycles after spi_req.

module tb_codec_cfg_seq;

    localparam int N    = 3;
    localparam int TMO  = 20;
    localparam int RMAX = 3;
    localparam int GAPC = 4;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [15:0] tbl [0:15];

    logic        start_a, spi_req_a, spi_wr_en_a, spi_done_a, busy_a, cfg_done_a, cfg_err_a;
    logic [3:0]  tbl_addr_a, err_index_a;
    logic [15:0] tbl_data_a, spi_data_tx_a;
    logic [7:0]  spi_data_rx_a;

    logic        start_b, spi_req_b, spi_wr_en_b, spi_done_b, busy_b, cfg_done_b, cfg_err_b;
    logic [3:0]  tbl_addr_b, err_index_b;
    logic [15:0] tbl_data_b, spi_data_tx_b;
    logic [7:0]  spi_data_rx_b;

    assign tbl_data_a = tbl[tbl_addr_a];
    assign tbl_data_b = tbl[tbl_addr_b];

    codec_cfg_seq #(.NUM_REGS(N), .VERIFY(1), .TIMEOUT(TMO), .RETRY_MAX(RMAX), .GAP(GAPC)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .tbl_addr(tbl_addr_a), .tbl_data(tbl_data_a),
        .spi_req(spi_req_a), .spi_wr_en(spi_wr_en_a), .spi_data_tx(spi_data_tx_a),
        .spi_data_rx(spi_data_rx_a), .spi_done(spi_done_a), .busy(busy_a),
        .cfg_done(cfg_done_a), .cfg_err(cfg_err_a), .err_index(err_index_a));

    codec_cfg_seq #(.NUM_REGS(N), .VERIFY(0), .TIMEOUT(TMO), .RETRY_MAX(RMAX), .GAP(GAPC)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .tbl_addr(tbl_addr_b), .tbl_data(tbl_data_b),
        .spi_req(spi_req_b), .spi_wr_en(spi_wr_en_b), .spi_data_tx(spi_data_tx_b),
        .spi_data_rx(spi_data_rx_b), .spi_done(spi_done_b), .busy(busy_b),
        .cfg_done(cfg_done_b), .cfg_err(cfg_err_b), .err_index(err_index_b));

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- SPI model for DUT a ----------------
    // mode 0: echo; 1: first read of reg 2 returns 0x00; 2: reg 3 reads 0xFF; 3: never done
    int          mode = 0;
    bit          first_rd_hit = 1'b0;
    int          nreq = 0;
    logic        log_wr [0:63];
    logic [15:0] log_tx [0:63];
    int          log_cyc [0:63];
    int          stab_err_a = 0, gap_err_a = 0, last_done_a = -1000;
    bit          pend_a = 1'b0;
    int          cnt_a = 0;
    logic [7:0]  resp_a;
    logic        held_wr_a;
    logic [15:0] held_tx_a;

    initial begin
        spi_done_a = 1'b0;
        spi_data_rx_a = 8'h00;
        forever begin
            @(negedge clk);
            spi_done_a = 1'b0;
            if (!rst) begin
                pend_a = 1'b0;
            end else begin
                if (pend_a) begin
                    if (spi_data_tx_a !== held_tx_a || spi_wr_en_a !== held_wr_a) stab_err_a++;
                    cnt_a--;
                    if (cnt_a == 0) begin
                        pend_a = 1'b0;
                        if (mode != 3) begin
                            spi_done_a = 1'b1;
                            spi_data_rx_a = resp_a;
                            last_done_a = cyc;
                        end
                    end
                end
                if (spi_req_a === 1'b1) begin
                    if (cyc - last_done_a <= GAPC) gap_err_a++;
                    if (nreq < 64) begin
                        log_wr[nreq] = spi_wr_en_a;
                        log_tx[nreq] = spi_data_tx_a;
                        log_cyc[nreq] = cyc;
                    end
                    nreq++;
                    held_wr_a = spi_wr_en_a;
                    held_tx_a = spi_data_tx_a;
                    pend_a = 1'b1;
                    cnt_a = LAT;
                    resp_a = spi_data_tx_a[15:8];
                    if (mode == 1 && spi_data_tx_a[6:0] == 7'd2 && !spi_wr_en_a && !first_rd_hit) begin
                        resp_a = 8'h00;
                        first_rd_hit = 1'b1;
                    end
                    if (mode == 2 && spi_data_tx_a[6:0] == 7'd3) resp_a = 8'hFF;
                end
            end
        end
    end

    // ---------------- SPI model for DUT b ----------------
    int          nreq_b = 0, rd_b = 0, stab_err_b = 0, gap_err_b = 0, last_done_b = -1000;
    logic [15:0] log_b [0:15];
    bit          pend_b = 1'b0;
    int          cnt_b = 0;
    logic        held_wr_b;
    logic [15:0] held_tx_b;

    initial begin
        spi_done_b = 1'b0;
        spi_data_rx_b = 8'h00;
        forever begin
            @(negedge clk);
            spi_done_b = 1'b0;
            if (!rst) begin
                pend_b = 1'b0;
            end else begin
                if (pend_b) begin
                    if (spi_data_tx_b !== held_tx_b || spi_wr_en_b !== held_wr_b) stab_err_b++;
                    cnt_b--;
                    if (cnt_b == 0) begin
                        pend_b = 1'b0;
                        spi_done_b = 1'b1;
                        spi_data_rx_b = held_tx_b[15:8];
                        last_done_b = cyc;
                    end
                end
                if (spi_req_b === 1'b1) begin
                    if (cyc - last_done_b <= GAPC) gap_err_b++;
                    if (spi_wr_en_b !== 1'b1) rd_b++;
                    if (nreq_b < 16) log_b[nreq_b] = spi_data_tx_b;
                    nreq_b++;
                    held_wr_b = spi_wr_en_b;
                    held_tx_b = spi_data_tx_b;
                    pend_b = 1'b1;
                    cnt_b = LAT;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_reset_a(input string tag);
        check({tag, "_spi_req"},   spi_req_a,     1'b0);
        check({tag, "_spi_wr_en"}, spi_wr_en_a,   1'b1);
        check({tag, "_data_tx"},   spi_data_tx_a, 16'h0000);
        check({tag, "_tbl_addr"},  tbl_addr_a,    4'd0);
        check({tag, "_busy"},      busy_a,        1'b0);
        check({tag, "_cfg_done"},  cfg_done_a,    1'b0);
        check({tag, "_cfg_err"},   cfg_err_a,     1'b0);
        check({tag, "_err_index"}, err_index_a,   4'd0);
    endtask

    task automatic start_a_pass();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("busy_at_T+1",     busy_a,     1'b1);
        check("tbl_addr_at_T+1", tbl_addr_a, 4'd0);
        check("no_req_at_T+1",   spi_req_a,  1'b0);
        check("flags_clr_T+1",   {cfg_done_a, cfg_err_a}, 2'b00);
        @(negedge clk);
        check("req_at_T+2",      spi_req_a,   1'b1);
        check("wr_en_at_T+2",    spi_wr_en_a, 1'b1);
    endtask

    task automatic wait_idle_a(input int lim);
        int n;
        n = 0;
        while (busy_a === 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("a_pass_ends_in_budget", busy_a === 1'b0, 1'b1);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] tx;
    } txn_t;

    typedef struct {
        int         mode;
        int         exp_reqs;
        logic       exp_done;
        logic       exp_err;
        logic [3:0] exp_eidx;
        int         watch_addr;
        int         exp_w;
        int         exp_r;
        int         exp_spacing;
    } scen_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        txn_t  exp_txn [6];
        scen_t sc [4];
        int    nw, nr, n;

        exp_txn[0] = '{1'b1, 16'h2A01};
        exp_txn[1] = '{1'b0, 16'h2A01};
        exp_txn[2] = '{1'b1, 16'h5502};
        exp_txn[3] = '{1'b0, 16'h5502};
        exp_txn[4] = '{1'b1, 16'h8003};
        exp_txn[5] = '{1'b0, 16'h8003};

        //          mode reqs done err eidx addr  w  r  spacing
        sc[0] = '{0,    6,  1'b1, 1'b0, 4'd0, 2, 1, 1, 0};
        sc[1] = '{1,    8,  1'b1, 1'b0, 4'd0, 2, 2, 2, 0};
        sc[2] = '{3,    4,  1'b0, 1'b1, 4'd0, 1, 4, 0, TMO + GAPC};
        sc[3] = '{2,    12, 1'b0, 1'b1, 4'd2, 3, 4, 4, 0};

        for (int i = 0; i < 16; i++) tbl[i] = 16'h0000;
        tbl[0] = 16'h2A01;
        tbl[1] = 16'h5502;
        tbl[2] = 16'h8003;

        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_a("rst");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int s = 0; s < 4; s++) begin
            mode = sc[s].mode;
            first_rd_hit = 1'b0;
            nreq = 0;
            start_a_pass();
            wait_idle_a(3000);
            @(negedge clk);
            check($sformatf("s%0d_req_count", s), nreq, sc[s].exp_reqs);
            check($sformatf("s%0d_cfg_done", s), cfg_done_a, sc[s].exp_done);
            check($sformatf("s%0d_cfg_err", s),  cfg_err_a,  sc[s].exp_err);
            if (sc[s].exp_err) check($sformatf("s%0d_err_index", s), err_index_a, sc[s].exp_eidx);
            nw = 0;
            nr = 0;
            for (int i = 0; i < nreq && i < 64; i++) begin
                if (log_tx[i][6:0] == 7'(sc[s].watch_addr)) begin
                    if (log_wr[i]) nw++;
                    else nr++;
                end
            end
            check($sformatf("s%0d_writes_reg%0d", s, sc[s].watch_addr), nw, sc[s].exp_w);
            check($sformatf("s%0d_reads_reg%0d", s, sc[s].watch_addr),  nr, sc[s].exp_r);
            if (sc[s].exp_spacing != 0) begin
                for (int i = 0; i + 1 < nreq && i < 63; i++)
                    check($sformatf("s%0d_req_spacing_%0d", s, i), log_cyc[i+1] - log_cyc[i], sc[s].exp_spacing);
            end
            if (sc[s].mode == 0) begin
                for (int i = 0; i < 6; i++) begin
                    check($sformatf("basic_wr_en_%0d", i), log_wr[i], exp_txn[i].wr);
                    check($sformatf("basic_tx_%0d", i),    log_tx[i], exp_txn[i].tx);
                end
            end
        end

        // Error flags hold with no start.
        repeat (10) @(negedge clk);
        check("err_holds", {cfg_err_a, cfg_done_a, err_index_a}, {1'b1, 1'b0, 4'd2});

        // Asynchronous reset during RD_WAIT, then restart from index 0.
        mode = 0;
        nreq = 0;
        start_a_pass();
        n = 0;
        while (!(spi_req_a === 1'b1 && spi_wr_en_a === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("saw_first_read_req", spi_req_a === 1'b1 && spi_wr_en_a === 1'b0, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_a("midrst");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nreq = 0;
        start_a_pass();
        wait_idle_a(3000);
        @(negedge clk);
        check("restart_req_count", nreq, 6);
        check("restart_first_tx", log_tx[0], 16'h2A01);
        check("restart_cfg_done", cfg_done_a, 1'b1);
        check("a_data_stable", stab_err_a, 0);
        check("a_gap_respected", gap_err_a, 0);

        // Protocol: VERIFY=0, extra start while busy.
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_busy_T+1", busy_b, 1'b1);
        repeat (8) @(negedge clk);
        check("b_busy_before_extra_start", busy_b, 1'b1);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (busy_b === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("b_pass_ends_in_budget", busy_b === 1'b0, 1'b1);
        @(negedge clk);
        check("b_req_count", nreq_b, 3);
        check("b_no_reads", rd_b, 0);
        check("b_tx_0", log_b[0], 16'h2A01);
        check("b_tx_1", log_b[1], 16'h5502);
        check("b_tx_2", log_b[2], 16'h8003);
        check("b_cfg_done", {cfg_done_b, cfg_err_b}, 2'b10);
        check("b_data_stable", stab_err_b, 0);
        check("b_gap_respected", gap_err_b, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/codec_cfg_seq.md
# codec_cfg_seq

Register-initialisation sequencer for the audio codec control port. Sits directly upstream of the SPI master: walks an external table of register writes, issues each as a write transaction (and optionally a read-back), compares the read-back value, retries on mismatch or timeout, and reports completion or error. It owns the SPI master's `req` / `wr_en` / `data_tx` inputs and consumes its `done` / `data_rx` outputs.

## Interface
- `NUM_REGS`, default 8: number of table entries, 1..16.
- `VERIFY`, default 1: 1 = read back and compare each write; 0 = write only.
- `TIMEOUT`, default 255: cycles from `spi_req` to `spi_done` before the attempt is declared failed; 8-bit counter.
- `RETRY_MAX`, default 3: retries per entry after the first attempt.
- `GAP`, default 4: idle cycles enforced after every `spi_done` before the next `spi_req`.
- `clk` in 1: system clock; the SPI master runs on the same clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a configuration pass.
- `tbl_addr` out 4: table index. The table responds combinationally.
- `tbl_data` in 16: table entry. [6:0] = register address, [7] = ignored, [15:8] = write data.
- `spi_req` out 1: transaction request to the SPI master, one-cycle pulse.
- `spi_wr_en` out 1: 1 = write, 0 = read.
- `spi_data_tx` out 16: transaction word, in the same layout as `tbl_data`.
- `spi_data_rx` in 8: read data from the SPI master.
- `spi_done` in 1: transaction-complete pulse from the SPI master.
- `busy` out 1: a pass is in progress.
- `cfg_done` out 1: level; the last pass completed without error.
- `cfg_err` out 1: level; the last pass aborted.
- `err_index` out 4: index of the failing entry. Valid while `cfg_err`=1.

## Operation
- States:
  - IDLE
  - FETCH
  - WR_REQ
  - WR_WAIT
  - RD_REQ
  - RD_WAIT
  - CHECK
  - GAP_WAIT
  - NEXT
  - FIN
  - FAIL
- `start` is honoured only in IDLE, FIN or FAIL. In those states it clears `cfg_done`, `cfg_err`, the index and the retry count, then goes to FETCH. `start` while `busy`=1 is ignored.
- FETCH: `tbl_addr` = index. Go to WR_REQ.
- WR_REQ:
  - Latch `spi_data_tx` <= `tbl_data` and set `spi_wr_en`=1.
  - Pulse `spi_req` for one cycle.
  - Clear the timeout counter and go to WR_WAIT.
- WR_WAIT:
  - On `spi_done`, go to GAP_WAIT; the GAP_WAIT exit then selects RD_REQ if `VERIFY`=1, else NEXT.
  - If the counter reaches `TIMEOUT` first, the attempt fails.
- RD_REQ: `spi_wr_en`=0 and `spi_data_tx` is unchanged. Pulse `spi_req` and go to RD_WAIT.
- RD_WAIT: on `spi_done`, capture `spi_data_rx` into `rd_data` in the same cycle and go to CHECK. Timeout behaves as in WR_WAIT.
- CHECK:
  - `rd_data` == `spi_data_tx[15:8]`: go to GAP_WAIT, then NEXT.
  - Otherwise the attempt fails.
- Failed attempt:
  - If retry count < `RETRY_MAX`: increment it, go to GAP_WAIT, then WR_REQ for the same entry.
  - Otherwise: `err_index` = index, `cfg_err`=1, go to FAIL.
- NEXT:
  - Clear the retry count.
  - If index == `NUM_REGS`-1: `cfg_done`=1, go to FIN.
  - Otherwise increment the index and go to FETCH.
- `spi_wr_en` and `spi_data_tx` are held stable from the `spi_req` cycle through the `spi_done` cycle, because the SPI master samples them throughout the frame.
- `spi_done` arriving in any state other than WR_WAIT or RD_WAIT is ignored.
- `busy` = 1 in every state except IDLE, FIN and FAIL.

## Timing
- Reset values: `spi_req`=0, `spi_wr_en`=1, `spi_data_tx`=0, `tbl_addr`=0, `busy`=0, `cfg_done`=0, `cfg_err`=0, `err_index`=0. State = IDLE.
- Reset asserted mid-transaction: all outputs go to their reset values immediately. The in-flight SPI frame is abandoned, and the SPI master is expected to finish it harmlessly.
- Latency after `start` in cycle T:
  - `busy`=1 in T+1.
  - `tbl_addr`=0 in T+1.
  - First `spi_req` pulse in T+2.
- Consecutive requests are separated by at least `GAP` cycles after `spi_done`, so the SPI master's counter has returned to 0.
- The timeout counter saturates and does not wrap.
- `spi_done` and a timeout in the same cycle: `spi_done` wins.
- `cfg_done` / `cfg_err` are set in the FIN / FAIL entry cycle and hold until the next accepted `start`.

## Test plan
- Basic pass:
  - Setup: `NUM_REGS`=3, `VERIFY`=1; table {0x2A01, 0x5502, 0x8003}; SPI model echoes the written data.
  - Stimulus: `start`.
  - Required: 6 `spi_req` pulses with `spi_wr_en` sequence 1,0,1,0,1,0 and `spi_data_tx` 0x2A01, 0x2A01, 0x5502, 0x5502, 0x8003, 0x8003; then `cfg_done`=1, `busy`=0.
- Retry then recover:
  - Setup: the model returns 0x00 on the first read of entry 1.
  - Required: entry 1 is written twice and read twice; `cfg_done`=1; `cfg_err`=0.
- Retry exhaustion:
  - Setup: the model always returns 0xFF for entry 2; `RETRY_MAX`=3.
  - Required: exactly 4 write/read pairs for entry 2; then `cfg_err`=1, `err_index`=2, `cfg_done`=0.
- Timeout:
  - Setup: the model never asserts `spi_done`; `TIMEOUT`=20.
  - Required: `spi_req` pulses 4 times, spaced 20+`GAP` cycles apart; then `cfg_err`=1, `err_index`=0.
- Protocol:
  - Stimulus: `start` pulsed while `busy`; `VERIFY`=0.
  - Required: the extra `start` has no effect; no read transactions occur; `spi_data_tx` is stable between each `spi_req` and its `spi_done`; the gap between `spi_done` and the next `spi_req` is ≥ `GAP`.
- Reset:
  - Stimulus: `rst`=0 asserted during RD_WAIT.
  - Required: all outputs return to their reset values asynchronously; a following `start` restarts from index 0.
